// File: rtl/fmc_arbiter.sv
// fmc_arbiter: round-robin arbiter and read sequencer that shares the single
// flash memory controller between several read requesters.
//
// One request is accepted at a time. The owner's address goes to the fmc with
// a one-cycle fmc_ready strobe. After a fixed number of read cycles the fmc
// data is captured and handed back to the owner with a one-cycle rvalid.
//
// Ports:
//   clk, n_rst      system clock, asynchronous active-low reset
//   req             per-requester level request, held until gnt
//   req_addr        packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt             one-hot pulse: request accepted, address latched
//   rvalid          one-hot pulse: rdata valid for that requester
//   rdata           captured read data, held until the next capture
//   busy            high whenever the sequencer is not idle
//   fmc_ready       one-cycle request strobe to the fmc
//   fmc_address     address to the fmc, held until the next grant
//   fmc_data_out    read data returned by the fmc
module fmc_arbiter #(
    parameter int N_REQ       = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int READ_CYCLES = 11
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic                    busy,
    output logic                    fmc_ready,
    output logic [ADDR_W-1:0]       fmc_address,
    input  logic [DATA_W-1:0]       fmc_data_out
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                        state;
    logic [PTR_W-1:0]              ptr;
    logic [PTR_W-1:0]              owner;
    logic [CNT_W-1:0]              cnt;

    logic [N_REQ-1:0][ADDR_W-1:0]  addr_v;
    logic                          sel_vld;
    logic [PTR_W-1:0]              sel_idx;
    int                            j;
    logic [PTR_W-1:0]              jj;

    assign addr_v = req_addr;

    // Round-robin pick: first set req bit at or above ptr, wrapping.
    // The loop runs from the farthest candidate down to ptr itself so the
    // closest match is the last one written and therefore wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        j       = 0;
        jj      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            jj = PTR_W'(j);
            if (req[jj]) begin
                sel_vld = 1'b1;
                sel_idx = jj;
            end
        end
    end

    // Sequencer: every output is a register, so req never reaches gnt
    // through combinational logic.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            gnt         <= '0;
            rvalid      <= '0;
            rdata       <= '0;
            busy        <= 1'b0;
            fmc_ready   <= 1'b0;
            fmc_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        owner       <= sel_idx;
                        fmc_address <= addr_v[sel_idx];
                        gnt         <= N_REQ'(1) << sel_idx;
                        fmc_ready   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt       <= '0;
                    fmc_ready <= 1'b0;
                    cnt       <= CNT_W'(READ_CYCLES - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rdata  <= fmc_data_out;
                        rvalid <= N_REQ'(1) << owner;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    rvalid <= '0;
                    busy   <= 1'b0;
                    // Next search starts just past the requester we served.
                    ptr    <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fmc_arbiter.md
Name: fmc_arbiter

Overview:
Round-robin arbiter and read sequencer that shares the single flash memory controller (fmc) between several read requesters, e.g. image loader and per-layer weight fetchers of the digit recognizer.
- Accepts one request at a time, drives the fmc request strobe and address, and waits a fixed read-cycle count.
- Captures fmc data and returns it to the owning requester with a one-cycle valid pulse.
- Sits between the requesters and fmc; fmc alone drives ce/oe/we toward the flash.

Parameters:
N_REQ, 3, number of requesters (2..8)
ADDR_W, 16, address width
DATA_W, 16, data width
READ_CYCLES, 11, clocks from fmc request strobe end to data capture (11 x 5 ns = 55 ns max flash read); must be >= 1

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester read request, level, held until gnt
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W], stable while req[i] high
gnt  out  N_REQ  one-hot one-cycle pulse: request accepted, address latched
rvalid  out  N_REQ  one-hot one-cycle pulse: rdata valid for that requester
rdata  out  DATA_W  read data, held until next capture
busy  out  1  high in every state except IDLE
fmc_ready  out  1  request strobe to fmc, one cycle
fmc_address  out  ADDR_W  address to fmc, held from ISSUE through DONE
fmc_data_out  in  DATA_W  read data from fmc

Behaviour:
- Reset (async, n_rst=0): state IDLE; gnt, rvalid, fmc_ready, busy = 0; rdata, fmc_address, counter = 0; priority pointer = 0; owner = 0.
- All outputs are registered; no combinational path from req to gnt.
- IDLE: if any req bit is high at an edge, select the first set bit searching from pointer upward with wrap. At that edge:
  - owner <= i; fmc_address <= req_addr[i].
  - gnt[i] <= 1 and fmc_ready <= 1, both for exactly one cycle.
  - state <= ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (1 cycle): next edge: fmc_ready <= 0, gnt <= 0, cnt <= READ_CYCLES-1, state <= WAIT.
- WAIT: each edge with cnt != 0 decrements cnt. An edge with cnt == 0 does the following, then state <= DONE:
  - rdata <= fmc_data_out.
  - rvalid[owner] <= 1.
- DONE (1 cycle): rvalid <= 0; pointer <= owner+1, wrapping N_REQ-1 -> 0; state <= IDLE.
- Latency: gnt asserted at edge E; rvalid asserted at edge E+READ_CYCLES+1. Back-to-back grants are READ_CYCLES+3 cycles apart.
- Requests are ignored outside IDLE. A requester whose req is still high after its gnt pulse is treated as a new request. Requesters must drop req in the cycle gnt is seen.
- A req deasserted before being granted is dropped; nothing is latched.
- Simultaneous requests are served in strict round-robin from the pointer. A single continuous requester is still served every READ_CYCLES+3 cycles.
- fmc_address is held stable from ISSUE until the next grant; a req_addr change after gnt has no effect.
- Reset mid-operation aborts the read: no rvalid is produced and the pointer returns to 0.
- READ_CYCLES = 1: WAIT lasts exactly one cycle.

Test Plan:
1. Single read: req[0]=1, req_addr[0]=16'd3, fmc_data_out=16'd111 → gnt[0] pulse with fmc_ready=1 and fmc_address=3 in the same cycle; rvalid[0] exactly 12 cycles later; rdata=111; busy high throughout; busy low after DONE.
2. Contention: req=3'b111 with addresses 5, 1, 2 from pointer 0 → grants in order 0, 1, 2 (addresses 5, 1, 2), spaced 14 cycles apart; each rvalid matches its grant's owner.
3. Round-robin fairness: after serving requester 1, req=3'b011 → requester 0 is not granted before 2? No: pointer=2, no req[2], so requester 0 is granted next, then requester 1.
4. Request withdrawal and ignore: req[2] pulsed 1 cycle while busy, then dropped → no gnt[2] and no rvalid[2]. Changing req_addr[0] after gnt[0] → fmc_address unchanged.
5. Reset mid-read: n_rst=0 for 2 cycles during WAIT → all outputs 0 immediately and no rvalid. A following req[1] with address 4 completes normally, granted from pointer 0.
6. Parameter corner: READ_CYCLES=1 build → rvalid 2 cycles after gnt; rdata captures the fmc_data_out value present at that edge.
